ring_decoder_checker: RTL and testbench
=======================================

RING_DECODER_CHECKER -- requirements
Module: ring_decoder_checker

Interface
REQ-001 SHALL have parameter LOCK_CNT, default 3: number of consecutive correct successor codes needed to enter LOCKED (range 2..7).
REQ-002 SHALL have parameter ERR_LIMIT, default 3: number of consecutive mismatches in SLIP before returning to HUNT (range 1..7).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-low (0 = reset).
REQ-005 SHALL have port ring_in  input  4  4-bit ring counter code under test.
REQ-006 SHALL have port ring_valid  input  1  ring_in is sampled on a rising clk only while this is 1.
REQ-007 SHALL have port index  output  2  binary position of the set bit of the last legal code.
REQ-008 SHALL have port index_valid  output  1  one-cycle pulse; index updated from a legal sample.
REQ-009 SHALL have port illegal  output  1  one-cycle pulse; sampled code is not one-hot.
REQ-010 SHALL have port err  output  1  one-cycle pulse; sequence mismatch while in LOCKED or SLIP.
REQ-011 SHALL have port lock  output  1  level; 1 while the FSM is in LOCKED.
REQ-012 SHALL have port wrap_cnt  output  8  count of completed ring rotations while locked.

Function
REQ-013 A code SHALL be legal iff exactly one bit of ring_in is 1; 0000 and any multi-hot value SHALL be illegal.
REQ-014 The successor of a code SHALL be its rotate-left by one: 0001->0010->0100->1000->0001.
REQ-015 index SHALL be 0,1,2,3 for 0001,0010,0100,1000 respectively.
REQ-016 All outputs SHALL be registered; the response to a sample SHALL appear in the cycle after the sampling edge (latency 1).
REQ-017 Cycles with ring_valid=0 SHALL change no state or counter; all pulse outputs SHALL be 0 in the following cycle.
REQ-018 The FSM SHALL have the states HUNT, ACQ, LOCKED and SLIP, and SHALL hold an expected-code register exp and a match counter mcnt.
REQ-019 HUNT: a legal sample -> ACQ, mcnt=1, exp=successor(sample); an illegal sample -> stay in HUNT.
REQ-020 ACQ: sample==exp -> mcnt+1 and exp=successor(sample), entering LOCKED when mcnt reaches LOCK_CNT; a legal non-successor sample -> stay in ACQ, mcnt=1, exp=successor(sample); an illegal sample -> HUNT, mcnt=0.
REQ-021 LOCKED: sample==exp -> stay; any mismatch -> SLIP, err pulse, ecnt=1.
REQ-022 In LOCKED and SLIP, exp SHALL advance to successor(exp) on every valid sample regardless of match (flywheel).
REQ-023 SLIP: sample==exp -> LOCKED, ecnt=0; a mismatch -> err pulse and ecnt+1, going to HUNT with ecnt=0 and mcnt=0 when ecnt reaches ERR_LIMIT.
REQ-024 illegal SHALL pulse for every illegal valid sample in every state; err and illegal MAY both pulse for the same sample.
REQ-025 index SHALL hold its last value on illegal samples and when ring_valid=0.
REQ-026 wrap_cnt SHALL increment by 1 when a matching 0001 is sampled in LOCKED (exp was 0001), SHALL wrap 255->0, and SHALL NOT be cleared by loss of lock.
REQ-027 Each state's transition SHALL be evaluated once per valid sample; no state SHALL be skipped within one edge.

Reset
REQ-028 rst=0 SHALL immediately, without a clock, force state=HUNT, exp=0001, mcnt=0, ecnt=0, index=0, index_valid=0, illegal=0, err=0, lock=0 and wrap_cnt=0.
REQ-029 While rst=0, ring_valid SHALL be ignored; reset SHALL take priority over any simultaneous sample.
REQ-030 Reset asserted mid-operation, including in LOCKED, SHALL discard all progress; reacquisition after release SHALL require the full LOCK_CNT.

Verification
REQ-031 Bench SHALL check: reset release, then valid 0001,0010,0100 -> index 0,1,2 with index_valid pulses; lock=1 in the cycle after 0100.
REQ-032 Bench SHALL check: locked, then 0001 after 1000 -> wrap_cnt 0->1; run 256 rotations -> wrap_cnt wraps to 0 while lock stays 1.
REQ-033 Bench SHALL check: locked with exp=0100, inject 1000 -> err=1, lock=0 (SLIP); the next sample 1000 matches the flywheel exp -> lock=1, no err.
REQ-034 Bench SHALL check: locked, inject 0000, then 0110, then 0011 -> three illegal and three err pulses; state=HUNT, lock=0; index unchanged.
REQ-035 Bench SHALL check: in ACQ with mcnt=2, sample 0001 after 0010 -> stay in ACQ with mcnt=1; then 0010,0100 -> lock=1.
REQ-036 Bench SHALL check: rst pulled low between clock edges while LOCKED with ring_valid=1 -> all outputs 0 before the next edge; after release, 0001,0010 -> lock stays 0.

Source files
------------

// File: rtl/ring_decoder_checker_if.sv
// Ring-code sample bus into the checker and its decoded/status results back out.
// Valid-only sampling, no ready: the checker accepts every sample with ring_valid=1.
interface ring_decoder_checker_if;
    logic [3:0] ring_in;
    logic       ring_valid;
    logic [1:0] index;
    logic       index_valid;
    logic       illegal;
    logic       err;
    logic       lock;
    logic [7:0] wrap_cnt;

    modport master (
        output ring_in, ring_valid,
        input  index, index_valid, illegal, err, lock, wrap_cnt
    );

    modport slave (
        input  ring_in, ring_valid,
        output index, index_valid, illegal, err, lock, wrap_cnt
    );
endinterface

// File: rtl/ring_decoder_checker.sv
// One-hot ring decoder with HUNT/ACQ/LOCKED/SLIP sequence lock; all outputs registered, latency 1.
// No backpressure: every valid sample is consumed; idle cycles freeze state and zero the pulses.
module ring_decoder_checker #(
    parameter int LOCK_CNT  = 3,
    parameter int ERR_LIMIT = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    ring_decoder_checker_if.slave   bus
);
    typedef enum logic [1:0] {HUNT, ACQ, LOCKED, SLIP} state_t;

    state_t     r_state;
    logic [3:0] r_exp;
    logic [2:0] r_mcnt;
    logic [2:0] r_ecnt;
    logic [1:0] r_index;
    logic       r_index_vld;
    logic       r_illegal;
    logic       r_err;
    logic       r_lock;
    logic [7:0] r_wrap;

    logic       w_legal;
    logic       w_match;
    logic [3:0] w_succ_in;
    logic [3:0] w_succ_exp;
    logic [1:0] w_enc;
    logic [2:0] w_mcnt_inc;
    logic [2:0] w_ecnt_inc;

    assign w_legal    = (bus.ring_in != 4'b0000) && ((bus.ring_in & (bus.ring_in - 4'd1)) == 4'b0000);
    assign w_match    = (bus.ring_in == r_exp);
    assign w_succ_in  = {bus.ring_in[2:0], bus.ring_in[3]};
    assign w_succ_exp = {r_exp[2:0], r_exp[3]};
    assign w_mcnt_inc = r_mcnt + 3'd1;
    assign w_ecnt_inc = r_ecnt + 3'd1;

    always_comb begin
        w_enc = 2'd0;
        case (bus.ring_in)
            4'b0010: w_enc = 2'd1;
            4'b0100: w_enc = 2'd2;
            4'b1000: w_enc = 2'd3;
            default: w_enc = 2'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= HUNT;
            r_exp       <= 4'b0001;
            r_mcnt      <= 3'd0;
            r_ecnt      <= 3'd0;
            r_index     <= 2'd0;
            r_index_vld <= 1'b0;
            r_illegal   <= 1'b0;
            r_err       <= 1'b0;
            r_lock      <= 1'b0;
            r_wrap      <= 8'd0;
        end else begin
            r_index_vld <= 1'b0;
            r_illegal   <= 1'b0;
            r_err       <= 1'b0;
            if (bus.ring_valid) begin
                r_index_vld <= w_legal;
                r_illegal   <= !w_legal;
                if (w_legal) begin
                    r_index <= w_enc;
                end
                case (r_state)
                    HUNT: begin
                        if (w_legal) begin
                            r_state <= ACQ;
                            r_mcnt  <= 3'd1;
                            r_exp   <= w_succ_in;
                        end
                    end
                    ACQ: begin
                        if (w_match) begin
                            r_mcnt <= w_mcnt_inc;
                            r_exp  <= w_succ_in;
                            if (w_mcnt_inc == 3'(LOCK_CNT)) begin
                                r_state <= LOCKED;
                                r_lock  <= 1'b1;
                            end
                        end else if (w_legal) begin
                            r_mcnt <= 3'd1;
                            r_exp  <= w_succ_in;
                        end else begin
                            r_state <= HUNT;
                            r_mcnt  <= 3'd0;
                            r_exp   <= 4'b0001;
                        end
                    end
                    // Flywheel: exp keeps rotating whether or not the sample agreed.
                    LOCKED: begin
                        r_exp <= w_succ_exp;
                        if (w_match) begin
                            if (r_exp == 4'b0001) begin
                                r_wrap <= r_wrap + 8'd1;
                            end
                        end else begin
                            r_state <= SLIP;
                            r_err   <= 1'b1;
                            r_ecnt  <= 3'd1;
                            r_lock  <= 1'b0;
                        end
                    end
                    SLIP: begin
                        r_exp <= w_succ_exp;
                        if (w_match) begin
                            r_state <= LOCKED;
                            r_lock  <= 1'b1;
                            r_ecnt  <= 3'd0;
                        end else begin
                            r_err <= 1'b1;
                            if (w_ecnt_inc >= 3'(ERR_LIMIT)) begin
                                r_state <= HUNT;
                                r_ecnt  <= 3'd0;
                                r_mcnt  <= 3'd0;
                                r_exp   <= 4'b0001;
                            end else begin
                                r_ecnt <= w_ecnt_inc;
                            end
                        end
                    end
                    default: r_state <= HUNT;
                endcase
            end
        end
    end

    assign bus.index       = r_index;
    assign bus.index_valid = r_index_vld;
    assign bus.illegal     = r_illegal;
    assign bus.err         = r_err;
    assign bus.lock        = r_lock;
    assign bus.wrap_cnt    = r_wrap;
endmodule

// File: tb/tb_ring_decoder_checker.sv
// Bench for ring_decoder_checker: vector table plus hand sequences, expected outputs queued at drive time.
module tb_ring_decoder_checker;
    logic clk = 1'b0;
    logic rst = 1'b0;

    ring_decoder_checker_if bus ();

    ring_decoder_checker #(.LOCK_CNT(3), .ERR_LIMIT(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] index;
        logic       iv;
        logic       ill;
        logic       err;
        logic       lock;
        logic [7:0] wrap;
    } out_t;

    typedef struct {
        string      name;
        logic       vld;
        logic [3:0] ring;
        out_t       exp;
    } vec_t;

    vec_t tbl[$];
    out_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic out_t mk(input logic [1:0] idx, input logic iv, input logic ill,
                                input logic err, input logic lock, input logic [7:0] wrap);
        out_t o;
        o.index = idx; o.iv = iv; o.ill = ill; o.err = err; o.lock = lock; o.wrap = wrap;
        return o;
    endfunction

    task automatic add(input string name, input logic vld, input logic [3:0] ring, input out_t e);
        vec_t v;
        v.name = name; v.vld = vld; v.ring = ring; v.exp = e;
        tbl.push_back(v);
    endtask

    task automatic check_out(input string name);
        out_t act;
        out_t e;
        act = {bus.index, bus.index_valid, bus.illegal, bus.err, bus.lock, bus.wrap_cnt};
        n_tests++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: no expected entry queued", name);
        end else begin
            e = sb_q.pop_front();
            if (act !== e) begin
                n_fail++;
                $display("FAIL %s: got idx=%0d iv=%b ill=%b err=%b lock=%b wrap=%0d, want idx=%0d iv=%b ill=%b err=%b lock=%b wrap=%0d",
                         name, act.index, act.iv, act.ill, act.err, act.lock, act.wrap,
                         e.index, e.iv, e.ill, e.err, e.lock, e.wrap);
            end
        end
    endtask

    task automatic step(input string name, input logic vld, input logic [3:0] ring, input out_t e);
        @(negedge clk);
        bus.ring_valid = vld;
        bus.ring_in    = ring;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        check_out(name);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.ring_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] rot [4];
        logic [1:0] ridx [4];
        logic [7:0] wrap_m;

        bus.ring_valid = 1'b0;
        bus.ring_in    = 4'b0000;

        // Lock, idle, wrap, flywheel slip/recover, illegal-driven loss, ACQ restart.
        add("acq_0001",     1, 4'b0001, mk(0, 1, 0, 0, 0, 0));
        add("idle",         0, 4'b0100, mk(0, 0, 0, 0, 0, 0));
        add("acq_0010",     1, 4'b0010, mk(1, 1, 0, 0, 0, 0));
        add("lock_0100",    1, 4'b0100, mk(2, 1, 0, 0, 1, 0));
        add("lock_1000",    1, 4'b1000, mk(3, 1, 0, 0, 1, 0));
        add("wrap_0001",    1, 4'b0001, mk(0, 1, 0, 0, 1, 1));
        add("lock_0010",    1, 4'b0010, mk(1, 1, 0, 0, 1, 1));
        add("slip_1000",    1, 4'b1000, mk(3, 1, 0, 1, 0, 1));
        add("relock_1000",  1, 4'b1000, mk(3, 1, 0, 0, 1, 1));
        add("ill_0000",     1, 4'b0000, mk(3, 0, 1, 1, 0, 1));
        add("ill_0110",     1, 4'b0110, mk(3, 0, 1, 1, 0, 1));
        add("ill_0011",     1, 4'b0011, mk(3, 0, 1, 1, 0, 1));
        add("hunt_0100",    1, 4'b0100, mk(2, 1, 0, 0, 0, 1));
        add("acq2_1000",    1, 4'b1000, mk(3, 1, 0, 0, 0, 1));
        add("acq_ill_0011", 1, 4'b0011, mk(3, 0, 1, 0, 0, 1));
        add("reacq_0001",   1, 4'b0001, mk(0, 1, 0, 0, 0, 1));
        add("reacq_0010",   1, 4'b0010, mk(1, 1, 0, 0, 0, 1));
        add("acq_restart",  1, 4'b0001, mk(0, 1, 0, 0, 0, 1));
        add("acq_m2",       1, 4'b0010, mk(1, 1, 0, 0, 0, 1));
        add("acq_lock",     1, 4'b0100, mk(2, 1, 0, 0, 1, 1));

        repeat (2) @(negedge clk);
        sb_q.push_back(mk(0, 0, 0, 0, 0, 0));
        check_out("reset_state");
        @(negedge clk);
        rst = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].name, tbl[i].vld, tbl[i].ring, tbl[i].exp);
        end

        // 256 full rotations after the first wrap: counter must roll back through zero.
        do_reset();
        step("w_acq_0001",  1, 4'b0001, mk(0, 1, 0, 0, 0, 0));
        step("w_acq_0010",  1, 4'b0010, mk(1, 1, 0, 0, 0, 0));
        step("w_lock_0100", 1, 4'b0100, mk(2, 1, 0, 0, 1, 0));
        rot[0] = 4'b1000; rot[1] = 4'b0001; rot[2] = 4'b0010; rot[3] = 4'b0100;
        ridx[0] = 2'd3;   ridx[1] = 2'd0;   ridx[2] = 2'd1;   ridx[3] = 2'd2;
        wrap_m = 8'd0;
        for (int r = 0; r < 256; r++) begin
            for (int p = 0; p < 4; p++) begin
                if (rot[p] == 4'b0001) wrap_m = wrap_m + 8'd1;
                step("w_rot", 1, rot[p], mk(ridx[p], 1, 0, 0, 1, wrap_m));
            end
        end
        n_tests++;
        if (bus.wrap_cnt !== 8'd0 || bus.lock !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_roll: got wrap=%0d lock=%b, want wrap=0 lock=1", bus.wrap_cnt, bus.lock);
        end
        step("w_pre_1000", 1, 4'b1000, mk(3, 1, 0, 0, 1, 0));
        step("w_pre_0001", 1, 4'b0001, mk(0, 1, 0, 0, 1, 1));

        // Asynchronous reset between edges while locked with a valid sample pending.
        @(negedge clk);
        bus.ring_valid = 1'b1;
        bus.ring_in    = 4'b0010;
        #2;
        rst = 1'b0;
        #1;
        sb_q.push_back(mk(0, 0, 0, 0, 0, 0));
        check_out("async_rst");
        @(posedge clk);
        #1;
        sb_q.push_back(mk(0, 0, 0, 0, 0, 0));
        check_out("rst_priority");
        @(negedge clk);
        bus.ring_valid = 1'b0;
        rst = 1'b1;
        step("post_rst_0001", 1, 4'b0001, mk(0, 1, 0, 0, 0, 0));
        step("post_rst_0010", 1, 4'b0010, mk(1, 1, 0, 0, 0, 0));
        step("post_rst_lock", 1, 4'b0100, mk(2, 1, 0, 0, 1, 0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
